// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified program/data memory arbiter.
package mem_arb_pkg;

  // Owner of the read response that appears in the cycle after a grant.
  typedef enum logic [1:0] {
    RSP_NONE = 2'd0,
    RSP_IF   = 2'd1,
    RSP_D    = 2'd2
  } rsp_owner_e;

  // Consecutive data grants tolerated while a fetch waits.
  localparam int DEFAULT_STARVE_LIMIT = 4;

  // Width of the starvation counter; limits up to 15 fit.
  localparam int STARVE_CNT_W = 4;

endpackage

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter: data-priority grant with a starvation guard
// for fetch, zero-latency grant, one-cycle read response routed to its owner.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int STARVE_LIMIT = DEFAULT_STARVE_LIMIT
) (
  input  logic              clk,
  input  logic              arstn,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_gnt_o,
  output logic              if_rvalid_o,
  output logic [31:0]       if_rdata_o,
  input  logic              d_req_i,
  input  logic              d_we_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic [31:0]       d_wdata_i,
  input  logic [3:0]        d_wmask_i,
  output logic              d_gnt_o,
  output logic              d_rvalid_o,
  output logic [31:0]       d_rdata_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_re_o,
  output logic              mem_we_o,
  output logic [31:0]       mem_wdata_o,
  output logic [3:0]        mem_wmask_o,
  input  logic [31:0]       mem_rdata_i
);

  localparam logic [STARVE_CNT_W-1:0] LIMIT_C = STARVE_CNT_W'(STARVE_LIMIT);

  logic                    if_gnt_s;
  logic                    d_gnt_s;
  logic [STARVE_CNT_W-1:0] starve_cnt_r;
  logic [STARVE_CNT_W-1:0] starve_cnt_next_s;
  rsp_owner_e              rsp_state_r;
  rsp_owner_e              rsp_next_s;

  // Grant selection: data first, fetch forced through once it has waited too long.
  always_comb begin
    if_gnt_s = 1'b0;
    d_gnt_s  = 1'b0;
    if (!arstn) begin
      if_gnt_s = 1'b0;
      d_gnt_s  = 1'b0;
    end else if (if_req_i && (starve_cnt_r == LIMIT_C)) begin
      if_gnt_s = 1'b1;
    end else if (d_req_i) begin
      d_gnt_s = 1'b1;
    end else begin
      if_gnt_s = if_req_i;
    end
  end

  assign if_gnt_o = if_gnt_s;
  assign d_gnt_o  = d_gnt_s;

  // Memory port follows the winner in the same cycle; idle port is all zero.
  always_comb begin
    mem_addr_o  = {ADDR_W{1'b0}};
    mem_re_o    = 1'b0;
    mem_we_o    = 1'b0;
    mem_wdata_o = 32'h0000_0000;
    mem_wmask_o = 4'b0000;
    if (if_gnt_s) begin
      mem_addr_o = if_addr_i;
      mem_re_o   = 1'b1;
    end else if (d_gnt_s) begin
      mem_addr_o  = d_addr_i;
      mem_re_o    = ~d_we_i;
      mem_we_o    = d_we_i;
      mem_wdata_o = d_wdata_i;
      mem_wmask_o = d_wmask_i;
    end else begin
      mem_addr_o = {ADDR_W{1'b0}};
    end
  end

  // Starvation count: data grants passed over a waiting fetch, saturating.
  always_comb begin
    starve_cnt_next_s = starve_cnt_r;
    if (!if_req_i || if_gnt_s) begin
      starve_cnt_next_s = {STARVE_CNT_W{1'b0}};
    end else if (d_gnt_s && (starve_cnt_r < LIMIT_C)) begin
      starve_cnt_next_s = starve_cnt_r + {{(STARVE_CNT_W-1){1'b0}}, 1'b1};
    end else begin
      starve_cnt_next_s = starve_cnt_r;
    end
  end

  // Starvation counter register.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      starve_cnt_r <= {STARVE_CNT_W{1'b0}};
    end else begin
      starve_cnt_r <= starve_cnt_next_s;
    end
  end

  // Response owner for next cycle: reads produce a response, writes do not.
  always_comb begin
    rsp_next_s = RSP_NONE;
    case ({if_gnt_s, d_gnt_s})
      2'b10:   rsp_next_s = RSP_IF;
      2'b01:   rsp_next_s = d_we_i ? RSP_NONE : RSP_D;
      2'b00:   rsp_next_s = RSP_NONE;
      default: rsp_next_s = RSP_NONE;
    endcase
  end

  // Response owner register; reset discards any pending response.
  always_ff @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      rsp_state_r <= RSP_NONE;
    end else begin
      rsp_state_r <= rsp_next_s;
    end
  end

  assign if_rvalid_o = (rsp_state_r == RSP_IF);
  assign d_rvalid_o  = (rsp_state_r == RSP_D);
  assign if_rdata_o  = mem_rdata_i;
  assign d_rdata_o   = mem_rdata_i;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized and directed bench for mem_arbiter against a cycle-level
// reference model of the arbitration rules and a shadow memory.
module tb_mem_arbiter;

  localparam int LIMIT = 4;

  logic        clk;
  logic        arstn;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic        if_gnt_o;
  logic        if_rvalid_o;
  logic [31:0] if_rdata_o;
  logic        d_req_i;
  logic        d_we_i;
  logic [31:0] d_addr_i;
  logic [31:0] d_wdata_i;
  logic [3:0]  d_wmask_i;
  logic        d_gnt_o;
  logic        d_rvalid_o;
  logic [31:0] d_rdata_o;
  logic [31:0] mem_addr_o;
  logic        mem_re_o;
  logic        mem_we_o;
  logic [31:0] mem_wdata_o;
  logic [3:0]  mem_wmask_o;
  logic [31:0] mem_rdata_i;

  int n_checks = 0;
  int n_errors = 0;

  mem_arbiter #(.ADDR_W(32), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .arstn(arstn),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
    .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
    .d_req_i(d_req_i), .d_we_i(d_we_i), .d_addr_i(d_addr_i),
    .d_wdata_i(d_wdata_i), .d_wmask_i(d_wmask_i), .d_gnt_o(d_gnt_o),
    .d_rvalid_o(d_rvalid_o), .d_rdata_o(d_rdata_o),
    .mem_addr_o(mem_addr_o), .mem_re_o(mem_re_o), .mem_we_o(mem_we_o),
    .mem_wdata_o(mem_wdata_o), .mem_wmask_o(mem_wmask_o), .mem_rdata_i(mem_rdata_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] m);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = new_w[8*b +: 8];
    return r;
  endfunction

  // Environment memory: synchronous single port, read data one cycle later.
  logic [31:0] env_mem [0:63];
  always @(posedge clk) begin
    if (mem_we_o) env_mem[mem_addr_o[7:2]] <= merge(env_mem[mem_addr_o[7:2]], mem_wdata_o, mem_wmask_o);
    if (mem_re_o) mem_rdata_i <= env_mem[mem_addr_o[7:2]];
  end

  // Reference model state.
  logic [31:0] ref_mem [0:63];
  int          waited;          // data grants taken while fetch was waiting
  bit          pend_if, pend_d; // a response is due this cycle for fetch / data
  logic [31:0] pend_data;
  int          n_waited;
  bit          n_pend_if, n_pend_d;
  logic [31:0] n_pend_data;
  bit          wr_due;
  logic [5:0]  wr_idx;
  logic [31:0] wr_val;
  bit          e_ifg, e_dg;
  bit          run_chk = 1'b0;

  // Evaluate the rules mid-cycle, compare, and prepare next-cycle model state.
  always @(negedge clk) begin
    if (run_chk) begin
      logic [31:0] e_addr;
      e_ifg = arstn && if_req_i && (waited >= LIMIT || !d_req_i);
      e_dg  = arstn && d_req_i && !e_ifg;
      e_addr = e_ifg ? if_addr_i : (e_dg ? d_addr_i : 32'h0);
      chk("if_gnt", {31'd0, if_gnt_o}, {31'd0, e_ifg});
      chk("d_gnt", {31'd0, d_gnt_o}, {31'd0, e_dg});
      chk("mem_addr", mem_addr_o, e_addr);
      chk("mem_re", {31'd0, mem_re_o}, {31'd0, e_ifg || (e_dg && !d_we_i)});
      chk("mem_we", {31'd0, mem_we_o}, {31'd0, e_dg && d_we_i});
      chk("mem_wdata", mem_wdata_o, e_dg ? d_wdata_i : 32'h0);
      chk("mem_wmask", {28'd0, mem_wmask_o}, e_dg ? {28'd0, d_wmask_i} : 32'h0);
      chk("if_rvalid", {31'd0, if_rvalid_o}, {31'd0, pend_if});
      chk("d_rvalid", {31'd0, d_rvalid_o}, {31'd0, pend_d});
      if (pend_if) chk("if_rdata", if_rdata_o, pend_data);
      if (pend_d) chk("d_rdata", d_rdata_o, pend_data);
      n_pend_if   = e_ifg;
      n_pend_d    = e_dg && !d_we_i;
      n_pend_data = ref_mem[e_addr[7:2]];
      wr_due      = e_dg && d_we_i;
      wr_idx      = d_addr_i[7:2];
      wr_val      = merge(ref_mem[d_addr_i[7:2]], d_wdata_i, d_wmask_i);
      if (!if_req_i || e_ifg) n_waited = 0;
      else if (e_dg && waited < LIMIT) n_waited = waited + 1;
      else n_waited = waited;
    end
  end

  // Commit model state at the clock edge; reset wipes it.
  always @(posedge clk or negedge arstn) begin
    if (!arstn) begin
      waited  <= 0;
      pend_if <= 1'b0;
      pend_d  <= 1'b0;
    end else if (run_chk) begin
      waited    <= n_waited;
      pend_if   <= n_pend_if;
      pend_d    <= n_pend_d;
      pend_data <= n_pend_data;
      if (wr_due) ref_mem[wr_idx] <= wr_val;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    if_req_i = 1'b0; d_req_i = 1'b0; d_we_i = 1'b0;
    if_addr_i = 32'h0; d_addr_i = 32'h0; d_wdata_i = 32'h0; d_wmask_i = 4'h0;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) begin
      env_mem[i] = (i < 16) ? (32'hA000_0000 + 32'(i)) : 32'h0;
      ref_mem[i] = env_mem[i];
    end
    n_waited = 0; n_pend_if = 1'b0; n_pend_d = 1'b0; n_pend_data = 32'h0;
    wr_due = 1'b0; wr_idx = 6'd0; wr_val = 32'h0; pend_data = 32'h0; mem_rdata_i = 32'h0;
    idle();
    arstn = 1'b1;
    #2 arstn = 1'b0;
    run_chk = 1'b1;
    repeat (3) @(posedge clk);
    #1 arstn = 1'b1;

    // Fetch only, back-to-back
    if_req_i = 1'b1; if_addr_i = 32'h00; cyc();
    if_addr_i = 32'h04; cyc();
    if_addr_i = 32'h08; cyc();
    idle();
    @(negedge clk);
    chk("fetch_last_word", if_rdata_o, 32'hA000_0002);
    cyc();

    // Data write then read
    d_req_i = 1'b1; d_we_i = 1'b1; d_addr_i = 32'h40; d_wdata_i = 32'hDEAD_BEEF; d_wmask_i = 4'hF;
    @(negedge clk);
    chk("wr_pulse", {31'd0, mem_we_o}, 32'd1);
    cyc();
    d_we_i = 1'b0; d_wdata_i = 32'h0; d_wmask_i = 4'h0;
    cyc();
    idle();
    @(negedge clk);
    chk("rd_after_wr", d_rdata_o, 32'hDEAD_BEEF);
    cyc();

    // Byte mask on a zero word
    d_req_i = 1'b1; d_we_i = 1'b1; d_addr_i = 32'h44; d_wdata_i = 32'h1122_3344; d_wmask_i = 4'b0100;
    cyc();
    d_we_i = 1'b0; d_wmask_i = 4'h0;
    cyc();
    idle();
    @(negedge clk);
    chk("byte_mask", d_rdata_o, 32'h0022_0000);
    cyc();

    // Contention: 4 data grants then 1 fetch, repeating
    if_req_i = 1'b1; if_addr_i = 32'h10; d_req_i = 1'b1; d_addr_i = 32'h20;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("contend_if", {31'd0, if_gnt_o}, (i % 5 == 4) ? 32'd1 : 32'd0);
      cyc();
    end
    idle();
    cyc();

    // Request drop while data wins; guard must start again from zero
    if_req_i = 1'b1; if_addr_i = 32'h0C; d_req_i = 1'b1; d_addr_i = 32'h24;
    cyc();
    if_req_i = 1'b0;
    cyc(); cyc();
    if_req_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("drop_then_if", {31'd0, if_gnt_o}, (i == 4) ? 32'd1 : 32'd0);
      cyc();
    end
    idle();
    cyc();

    // Reset mid-read
    d_req_i = 1'b1; d_addr_i = 32'h40;
    @(negedge clk);
    chk("rst_rd_gnt", {31'd0, d_gnt_o}, 32'd1);
    #2 arstn = 1'b0;
    d_req_i = 1'b0;
    @(negedge clk);
    chk("rst_no_rvalid", {31'd0, d_rvalid_o}, 32'd0);
    @(posedge clk);
    #1 arstn = 1'b1;
    if_req_i = 1'b1; if_addr_i = 32'h08;
    cyc();
    idle();
    @(negedge clk);
    chk("post_rst_fetch", if_rdata_o, 32'hA000_0002);
    cyc();

    // Randomized traffic, losers usually hold their request
    for (int c = 0; c < 400; c++) begin
      if (!(if_req_i && !e_ifg && ($urandom_range(3) != 0))) begin
        if_req_i  = ($urandom_range(2) != 0);
        if_addr_i = 32'($urandom_range(63)) << 2;
      end
      if (!(d_req_i && !e_dg && ($urandom_range(3) != 0))) begin
        d_req_i   = ($urandom_range(1) != 0);
        d_we_i    = ($urandom_range(2) == 0);
        d_addr_i  = 32'($urandom_range(63)) << 2;
        d_wdata_i = $urandom;
        d_wmask_i = 4'($urandom_range(15));
      end
      cyc();
    end
    idle();
    cyc(); cyc();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares one single-port synchronous memory between the core's instruction-fetch and data-access paths, replacing the split i_mem/d_mem arrangement for a unified program/data memory. Grants at most one access per cycle with data priority, bounded by a starvation guard so fetch always progresses. Sits between `core` and a unified memory instance in the top level. It returns read data one cycle after grant with a per-requester valid strobe.

## Interface
- `ADDR_W`, 32: address width of all ports.
- `STARVE_LIMIT`, 4: maximum consecutive data grants while a fetch request waits; legal range 1–15.
- `clk` in 1: clock, all state on rising edge.
- `arstn` in 1: reset, asynchronous, active-low.
- `if_req_i` in 1: fetch request; held with a stable address until granted.
- `if_addr_i` in ADDR_W: fetch byte address.
- `if_gnt_o` out 1: fetch accepted this cycle.
- `if_rvalid_o` out 1: fetch data valid this cycle.
- `if_rdata_o` out 32: fetch read data.
- `d_req_i` in 1: data request; held stable until granted.
- `d_we_i` in 1: 1 = write, 0 = read.
- `d_addr_i` in ADDR_W: data byte address.
- `d_wdata_i` in 32: write data.
- `d_wmask_i` in 4: byte write mask.
- `d_gnt_o` out 1: data access accepted this cycle.
- `d_rvalid_o` out 1: data read data valid (reads only).
- `d_rdata_o` out 32: data read data.
- `mem_addr_o` out ADDR_W: memory address.
- `mem_re_o` out 1: memory read enable.
- `mem_we_o` out 1: memory write enable.
- `mem_wdata_o` out 32: memory write data.
- `mem_wmask_o` out 4: memory byte mask.
- `mem_rdata_i` in 32: memory read data, valid one cycle after `mem_re_o`.

## Operation
- Grant logic is combinational from requests and starvation state. Exactly one or zero grants per cycle.
- Priority: data wins if `d_req_i`, unless the starvation count equals `STARVE_LIMIT` and `if_req_i` is high. In that case fetch wins.
- Starvation counter (4 bit):
  - Increments on each data grant while `if_req_i` is high.
  - Clears on a fetch grant or whenever `if_req_i` is low.
  - Saturates at `STARVE_LIMIT`.
- Memory port is driven from the winner in the same cycle:
  - Fetch grant: `mem_re_o`=1, `mem_we_o`=0.
  - Data grant: `mem_we_o`=`d_we_i`, `mem_re_o`=!`d_we_i`; wdata and mask passed through.
  - No grant: re/we/mask are 0, and addr/wdata are 0.
- Response owner FSM, registered, with states RSP_NONE, RSP_IF and RSP_D:
  - Next state is RSP_IF after a fetch grant.
  - Next state is RSP_D after a data read grant.
  - Next state is RSP_NONE otherwise, including after a data write.
- `if_rvalid_o` = (state==RSP_IF); `d_rvalid_o` = (state==RSP_D).
- `if_rdata_o` = `d_rdata_o` = `mem_rdata_i`; contents are meaningful only with the matching rvalid.
- A write completes at the grant edge and produces no response.

## Timing
- Grant latency is 0 cycles: a grant may occur in the same cycle a request rises.
- Read latency is 1 cycle: rvalid and rdata appear in the cycle after the grant.
- Fully pipelined: a new grant may be issued in the same cycle as the previous response, giving throughput of 1 access per cycle.
- Simultaneous fetch and data requests are resolved by the priority rule. The loser sees no grant and must hold its request.
- Requests dropped before grant are ignored; no state is kept.
- During `arstn` low:
  - All grants and memory enables are forced to 0.
  - FSM is RSP_NONE, so both rvalids are 0.
  - Starvation count is 0; addr/wdata/mask are 0.
- Reset asserted mid-read: the pending response is discarded, and no rvalid appears after release.
- First grant is possible in the first clock edge cycle after `arstn` rises.

## Structure
- Package `mem_arb_pkg` holds:
  - `rsp_owner_e` enum (RSP_NONE, RSP_IF, RSP_D).
  - The default `STARVE_LIMIT` constant.
  - The starvation counter width constant (4).
- Single module; no sub-module needed. The grant mux, counter and FSM are each small.

## Test plan
- **Fetch only.** `if_req_i` held with addr 0x00, then 0x04, 0x08, back-to-back.
  - Expect a grant every cycle.
  - `if_rvalid_o` one cycle later carries each word: 3 responses over 4 cycles.
- **Data write then read.** Write 0xDEADBEEF with mask 0xF to 0x40, then read 0x40.
  - Write: `mem_we_o` pulse, no rvalid.
  - Read: `d_rvalid_o` next cycle with 0xDEADBEEF.
- **Contention.** Both request every cycle, `STARVE_LIMIT`=4.
  - Expect 4 data grants, then 1 fetch grant, repeating.
  - Each rvalid is routed to the correct owner.
- **Byte mask.** Write 0x11223344 with mask 0b0100 to a word holding 0.
  - Read returns 0x00220000.
- **Reset mid-read.** Data read granted, then `arstn` pulled low before the next edge.
  - No `d_rvalid_o` appears; all outputs are 0 during reset.
  - After release the first fetch completes normally.
- **Request drop.** `if_req_i` high for one cycle while data wins, then low.
  - Starvation count returns to 0.
  - No fetch grant or rvalid occurs.
